mod_mult_serial: RTL and testbench



---
 rtl/mod_mult_serial_if.sv | 25 ++
 rtl/mod_mult_serial.sv | 106 ++++++++++
 tb/tb_mod_mult_serial.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mod_mult_serial_if.sv
// Start/operand/result bundle for mod_mult_serial; the requester is the master and the multiplier is the slave.
interface mod_mult_serial_if #(
    parameter int WIDTH = 256
);
    localparam int KW = $clog2(WIDTH + 2);

    logic [WIDTH-1:0] i_N;
    logic [WIDTH:0]   i_a;
    logic [WIDTH-1:0] i_b;
    logic [KW-1:0]    i_k;
    logic             i_input_ready;
    logic [WIDTH-1:0] o_m;
    logic             o_output_ready;
    logic             o_busy;

    modport master (
        output i_N, i_a, i_b, i_k, i_input_ready,
        input  o_m, o_output_ready, o_busy
    );

    modport slave (
        input  i_N, i_a, i_b, i_k, i_input_ready,
        output o_m, o_output_ready, o_busy
    );
endinterface

// File: rtl/mod_mult_serial.sv
// Bit-serial (a mod 2^k) * b mod N, one multiplier bit per clock, LSB first.
// Optional MOD_MULT_EARLY_EXIT_EN: finish as soon as no set multiplier bits remain.
module mod_mult_serial #(
    parameter  int WIDTH = 256,
    localparam int KW    = $clog2(WIDTH + 2)
) (
    input logic               i_clk,
    input logic               i_rst,
    mod_mult_serial_if.slave  bus
);
    typedef enum logic {S_IDLE, S_PROC} state_t;

    localparam logic [KW-1:0] KMAX = KW'(WIDTH + 1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_N, r_t, r_acc, r_m;
    logic [WIDTH:0]   r_A;
    logic [KW-1:0]    r_cnt, r_keff;
    logic             r_out_rdy;

    logic [KW-1:0]    w_keff;
    logic [WIDTH:0]   w_amask, w_N_x, w_sum, w_dbl;
    logic [WIDTH-1:0] w_acc_nxt, w_t_nxt;
    logic             w_last;

    assign w_keff = (bus.i_k > KMAX) ? KMAX : bus.i_k;

    always_comb begin
        w_amask = '0;
        for (int i = 0; i <= WIDTH; i++)
            if (i < int'(w_keff)) w_amask[i] = bus.i_a[i];
    end

    // Both sums fit in WIDTH+1 bits because acc, t < N; ">=" so a value equal to N reduces to 0.
    assign w_N_x     = {1'b0, r_N};
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_t};
    assign w_dbl     = {r_t, 1'b0};
    assign w_acc_nxt = !r_A[0]        ? r_acc :
                       (w_sum >= w_N_x) ? WIDTH'(w_sum - w_N_x) : w_sum[WIDTH-1:0];
    assign w_t_nxt   = (w_dbl >= w_N_x) ? WIDTH'(w_dbl - w_N_x) : w_dbl[WIDTH-1:0];

`ifdef MOD_MULT_EARLY_EXIT_EN
    assign w_last = (r_cnt == r_keff - KW'(1)) || (r_A[WIDTH:1] == '0);
`else
    assign w_last = (r_cnt == r_keff - KW'(1));
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.i_input_ready && w_keff != '0) w_state_nxt = S_PROC;
            S_PROC:  if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_N       <= '0;
            r_t       <= '0;
            r_acc     <= '0;
            r_m       <= '0;
            r_A       <= '0;
            r_cnt     <= '0;
            r_keff    <= '0;
            r_out_rdy <= 1'b0;
        end else begin
            r_out_rdy <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.i_input_ready) begin
                    r_N    <= bus.i_N;
                    r_t    <= bus.i_b;
                    r_acc  <= '0;
                    r_cnt  <= '0;
                    r_A    <= w_amask;
                    r_keff <= w_keff;
                    // Zero multiplier bits: the product is trivially 0, complete without processing.
                    if (w_keff == '0) begin
                        r_m       <= '0;
                        r_out_rdy <= 1'b1;
                    end
                end
                S_PROC: begin
                    r_acc <= w_acc_nxt;
                    r_t   <= w_t_nxt;
                    r_A   <= r_A >> 1;
                    r_cnt <= r_cnt + KW'(1);
                    if (w_last) begin
                        r_m       <= w_acc_nxt;
                        r_out_rdy <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_m            = r_m;
    assign bus.o_output_ready = r_out_rdy;
    assign bus.o_busy         = (r_state == S_PROC);
endmodule

// File: tb/tb_mod_mult_serial.sv
// Scoreboard bench for mod_mult_serial: WIDTH=8 directed vectors plus WIDTH=256 Montgomery-conversion runs.
module tb_mod_mult_serial;
`ifdef MOD_MULT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        logic [255:0] m;
        int           start;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    exp_t q8[$];
    exp_t q256[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mod_mult_serial_if #(.WIDTH(8))   b8 ();
    mod_mult_serial_if #(.WIDTH(256)) b256 ();

    mod_mult_serial #(.WIDTH(8))   dut8   (.i_clk(clk), .i_rst(rst), .bus(b8));
    mod_mult_serial #(.WIDTH(256)) dut256 (.i_clk(clk), .i_rst(rst), .bus(b256));

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Latency of an 8-bit operation: k_eff cycles, or up to the highest set masked bit with early exit.
    function automatic int exp_lat(input int a, input int k);
        int ke;
        int hi;
        ke = (k > 9) ? 9 : k;
        hi = 0;
        for (int i = 0; i < ke; i++) if (a[i]) hi = i + 1;
        if (ke == 0) return 0;
        if (EE) return (hi < 1) ? 1 : hi;
        return ke;
    endfunction

    // Monitors: pop on every completion pulse; check result, pulse timing and busy-cycle count.
    initial begin : mon8
        int   bc;
        exp_t e;
        bc = 0;
        forever begin
            @(negedge clk);
            if (b8.o_output_ready) begin
                if (q8.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL mon8 unexpected pulse at cycle %0d: got pulse expected none", cyc);
                end else begin
                    e = q8.pop_front();
                    chk("m8", {248'd0, b8.o_m}, e.m);
                    chk("lat8", 256'(cyc - e.start), 256'(e.lat));
                    chk("busy8", 256'(bc), 256'(e.lat));
                end
                bc = 0;
            end else if (b8.o_busy) bc++;
            else bc = 0;
        end
    end

    initial begin : mon256
        int   bc;
        exp_t e;
        bc = 0;
        forever begin
            @(negedge clk);
            if (b256.o_output_ready) begin
                if (q256.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL mon256 unexpected pulse at cycle %0d: got pulse expected none", cyc);
                end else begin
                    e = q256.pop_front();
                    chk("m256", b256.o_m, e.m);
                    chk("lat256", 256'(cyc - e.start), 256'(e.lat));
                    chk("busy256", 256'(bc), 256'(e.lat));
                end
                bc = 0;
            end else if (b256.o_busy) bc++;
            else bc = 0;
        end
    end

    task automatic drain8();
        int t;
        t = 0;
        while (q8.size() != 0 && t < 60) begin @(negedge clk); t++; end
        if (q8.size() != 0) begin
            nchk++; nerr++;
            $display("FAIL drain8 timeout: got %0d pending expected 0", q8.size());
            q8.delete();
        end
    endtask

    task automatic set8(input int n, input int a, input int b, input int k);
        b8.i_N = 8'(n);
        b8.i_a = 9'(a);
        b8.i_b = 8'(b);
        b8.i_k = 4'(k);
    endtask

    task automatic run8(input int n, input int a, input int b, input int k, input int m);
        exp_t e;
        @(negedge clk);
        set8(n, a, b, k);
        b8.i_input_ready = 1'b1;
        e.m = 256'(m); e.start = cyc + 1; e.lat = exp_lat(a, k);
        q8.push_back(e);
        @(negedge clk);
        b8.i_input_ready = 1'b0;
        drain8();
    endtask

    task automatic run256(input logic [255:0] n, input logic [255:0] b, input logic [255:0] m);
        exp_t e;
        int   t;
        @(negedge clk);
        b256.i_N = n;
        b256.i_a = {1'b1, 256'd0};
        b256.i_b = b;
        b256.i_k = 9'd257;
        b256.i_input_ready = 1'b1;
        e.m = m; e.start = cyc + 1; e.lat = 257;
        q256.push_back(e);
        @(negedge clk);
        b256.i_input_ready = 1'b0;
        t = 0;
        while (q256.size() != 0 && t < 400) begin @(negedge clk); t++; end
        if (q256.size() != 0) begin
            nchk++; nerr++;
            $display("FAIL drain256 timeout: got %0d pending expected 0", q256.size());
            q256.delete();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        bit   seen;
        b8.i_input_ready = 1'b0;
        set8(0, 0, 0, 0);
        b256.i_N = '0; b256.i_a = '0; b256.i_b = '0; b256.i_k = '0;
        b256.i_input_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_m8", {248'd0, b8.o_m}, 256'd0);
        chk("rst_busy8", {255'd0, b8.o_busy}, 256'd0);
        chk("rst_rdy8", {255'd0, b8.o_output_ready}, 256'd0);
        chk("rst_m256", b256.o_m, 256'd0);
        rst = 1'b0;

        run8(13, 5, 7, 9, 9);        // 35 mod 13
        run8(13, 256, 1, 9, 9);      // 256 mod 13
        run8(13, 1, 12, 9, 12);      // no spurious reduction
        run8(255, 255, 254, 9, 0);   // hits acc+t == N
        run8(13, 1, 7, 9, 7);
        run8(13, 0, 7, 9, 0);
        run8(13, 5, 7, 0, 0);        // k=0 immediate completion
        run8(13, 5, 7, 15, 9);       // k clamps to 9
        run8(13, 261, 7, 8, 9);      // bit 8 of a masked off
        run8(13, 3, 5, 2, 2);

        // Back-to-back with start held high: second op captured at the pulse edge.
        @(negedge clk);
        set8(13, 5, 7, 9);
        b8.i_input_ready = 1'b1;
        e.m = 256'd9; e.start = cyc + 1; e.lat = exp_lat(5, 9);
        q8.push_back(e);
        @(negedge clk);
        set8(13, 3, 5, 2);
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (b8.o_output_ready) seen = 1'b1;
        end
        if (!seen) begin
            nchk++; nerr++;
            $display("FAIL b2b timeout: got no pulse expected pulse");
        end else begin
            e.m = 256'd2; e.start = cyc + 1; e.lat = exp_lat(3, 2);
            q8.push_back(e);
        end
        @(negedge clk);
        b8.i_input_ready = 1'b0;
        drain8();
        repeat (12) @(negedge clk);

        // Reset in cycle 4 of a k=9 operation discards it.
        @(negedge clk);
        set8(13, 5, 7, 9);
        b8.i_input_ready = 1'b1;
        @(negedge clk);
        b8.i_input_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_m8", {248'd0, b8.o_m}, 256'd0);
        chk("abort_busy8", {255'd0, b8.o_busy}, 256'd0);
        chk("abort_rdy8", {255'd0, b8.o_output_ready}, 256'd0);
        rst = 1'b0;
        run8(13, 5, 7, 9, 9);
        repeat (12) @(negedge clk);

        // WIDTH=256 Montgomery conversion b*2^256 mod N with hand-reducible moduli.
        run256({{254{1'b1}}, 2'b01}, 256'd5, 256'd15);                          // N=2^256-3, 2^256 = 3
        run256({{254{1'b1}}, 2'b01}, {{254{1'b1}}, 2'b00}, {{253{1'b1}}, 3'b010}); // (N-1)*3 = N-3
        run256({256{1'b1}}, 256'd12345, 256'd12345);                             // N=2^256-1, 2^256 = 1

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
